jt12_kon_multi: RTL and testbench
=================================

// Module: jt12_kon_multi
// PURPOSE
//  Parametrised key-on state engine for the FM operator pipeline. Holds one key
//  bit per operator slot in a circular shift register that rotates with the slot
//  sequencer. Register writes reach it through a pending-request handshake.
//  Adds CSM auto key-on and per-slot key-on/key-off edge pulses that feed the
//  envelope generator.
// PARAMETERS
//  NCH     6  number of FM channels (1..8)
//  NOP     4  operators per channel (fixed 4 for OPN slot order; 2 allowed)
//  CSM_CH  2  channel index forced on by CSM timer-A overflow
//  CHW     3  channel index width, >= clog2(NCH)
// PORTS
//  clk         in   1    system clock
//  rst         in   1    asynchronous reset, active-high
//  clk_en      in   1    slot advance enable; all state changes only when high
//  cur_ch      in   CHW  channel of the slot now in the pipeline
//  cur_op      in   2    operator of the current slot, sequencer order 0..NOP-1
//  up_keyon    in   1    one-cycle write strobe (key-on register written)
//  keyon_ch    in   CHW  target channel of the write
//  keyon_op    in   NOP  operator mask of the write, bit0=S1 .. bit3=S4
//  csm         in   1    CSM mode enable
//  overflow_A  in   1    timer A overflow strobe
//  keyon_II    out  1    registered key level for the current slot
//  kon_pls     out  1    current slot went 0->1 since its previous visit
//  koff_pls    out  1    current slot went 1->0 since its previous visit
//  busy        out  1    a write request is pending
// BEHAVIOUR
//  - Reset: key ring, last-output ring, pending and CSM flags all cleared.
//    Outputs keyon_II, kon_pls, koff_pls and busy are 0.
//  - Every clk_en cycle:
//    * the key ring (NCH*NOP stages) shifts by one;
//    * the outputs register the current slot, so latency is 1 clk_en cycle.
//  - Slot mapping, cur_op -> mask bit: 0->S1, 1->S3, 2->S2, 3->S4.
//    With NOP=2: 0->S1, 1->S2.
//  - Write handshake:
//    * on up_keyon & clk_en, latch keyon_ch and keyon_op, and set busy;
//    * while busy and cur_ch==pend_ch, the stored bit = mask bit of cur_op;
//    * busy clears after the slot with cur_op==NOP-1 of pend_ch is written;
//    * a new write while busy replaces the request (latest wins). Slots already
//      written keep their values; application restarts at the next matching slot;
//    * if up_keyon and the final slot coincide, the new request is latched and
//      busy stays 1;
//    * up_keyon without clk_en is ignored;
//    * keyon_ch >= NCH: busy is set, no slot matches, and busy clears after one
//      full ring pass (NCH*NOP clk_en cycles, counted).
//  - CSM:
//    * overflow_A & csm & clk_en sets csm_pend;
//    * at the next visit of CSM_CH op0, csm_pend arms one pass over the NOP
//      slots of CSM_CH;
//    * during that pass keyon_II = stored | 1, and the stored bits are unchanged;
//    * the flag clears after op NOP-1 of CSM_CH;
//    * repeated overflows during a pending pass merge into one pass;
//    * csm dropping to 0 cancels csm_pend, and any pass in progress finishes.
//  - Edges:
//    * a second ring holds the last keyon_II per slot;
//    * kon_pls = new & ~last, koff_pls = ~new & last;
//    * both are registered with keyon_II and are mutually exclusive.
//  - Reset mid-operation discards pending writes and CSM immediately.
// STRUCTURE
//  - Shared package jt12_kon_pkg:
//    * OP_ORDER slot-to-mask table;
//    * NOP/NCH limits;
//    * function ring_len().
//  - Sub-module: jt12_sh_rst, instantiated twice with width 1, stages NCH*NOP,
//    rstval 0: one for the key ring, one for the last-output ring.
//  - Request/CSM control logic and the pass counter stay in this module.
// TESTING
//  1. Reset then idle 48 clk_en: keyon_II, kon_pls, koff_pls and busy stay 0.
//  2. Write ch1 mask 4'b1111: busy 1 until ch1 op3. The next pass shows
//     keyon_II=1 on 4 slots with kon_pls=1, and 0 on the others.
//  3. Write ch1 mask 4'b0000 after test 2: koff_pls=1 on exactly the 4 ch1 slots,
//     and the following pass shows no pulses.
//  4. csm=1, one overflow_A: one pass of ch2 with keyon_II=1 on 4 slots and
//     kon_pls. On the next pass koff_pls fires, and the stored ring is unchanged.
//  5. Write ch0 0b0001, then ch0 0b0100 before ch0 arrives: only S3 ends at 1.
//     busy clears once.
//  6. Assert rst mid-pass with busy=1: all outputs drop to 0 asynchronously,
//     and the ring reads 0 afterwards.

Source files
------------

// File: rtl/jt12_kon_pkg.sv
// Shared definitions for the key-on state engine.
//  - OP_ORDER : maps the sequencer operator index (0..3) to the key-on mask
//               bit for 4-operator OPN ordering (S1, S3, S2, S4).
//  - NCH_MAX / NOP_MAX : supported channel and operator counts.
//  - ring_len : number of slots in one full sequencer pass.
//  - op_bit   : mask bit selected by a sequencer operator index.
package jt12_kon_pkg;

  localparam int NCH_MAX = 8;
  localparam int NOP_MAX = 4;

  localparam logic [1:0] OP_ORDER [NOP_MAX] = '{2'd0, 2'd2, 2'd1, 2'd3};

  function automatic int ring_len(input int nch, input int nop);
    return nch * nop;
  endfunction

  // 2-operator mode keeps the natural order: op0 -> S1, op1 -> S2.
  function automatic logic [1:0] op_bit(input logic [1:0] op, input int nop);
    return (nop == NOP_MAX) ? OP_ORDER[op] : op;
  endfunction

endpackage

// File: rtl/jt12_sh_rst.sv
// Clock-enabled shift register with asynchronous reset value.
// Ports:
//  clk    : system clock
//  rst    : asynchronous reset, active-high, loads RSTVAL in every stage
//  clk_en : shift enable
//  din    : value entering stage 0
//  drop   : value leaving the last stage (din delayed by STAGES enables)
module jt12_sh_rst #(
  parameter int               WIDTH  = 1,
  parameter int               STAGES = 24,
  parameter logic [WIDTH-1:0] RSTVAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] drop
);

  logic [WIDTH-1:0] bits [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) bits[i] <= RSTVAL;
    end else if (clk_en) begin
      bits[0] <= din;
      for (int i = 1; i < STAGES; i++) bits[i] <= bits[i-1];
    end
  end

  assign drop = bits[STAGES-1];

endmodule

// File: rtl/jt12_kon_multi.sv
// Key-on state engine for the FM operator pipeline.
// One key bit per operator slot circulates in a ring that advances with the
// slot sequencer, so the ring output always holds the stored key of the slot
// now in the pipeline. Register writes are applied slot by slot while a
// request is pending; CSM timer-A overflows force one key-on pass over the
// CSM channel; a second ring remembers the last output level per slot to
// produce key-on / key-off edge pulses.
// Ports:
//  clk, rst            : clock, asynchronous active-high reset
//  clk_en              : slot advance enable
//  cur_ch, cur_op      : slot currently in the pipeline
//  up_keyon            : key-on register write strobe
//  keyon_ch, keyon_op  : write target channel and operator mask (bit0=S1)
//  csm, overflow_A     : CSM mode enable and timer A overflow strobe
//  keyon_II            : registered key level of the current slot
//  kon_pls, koff_pls   : registered rising / falling edge of that level
//  busy                : a write request is pending
module jt12_kon_multi
  import jt12_kon_pkg::*;
#(
  parameter int NCH    = 6,
  parameter int NOP    = 4,
  parameter int CSM_CH = 2,
  parameter int CHW    = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clk_en,
  input  logic [CHW-1:0] cur_ch,
  input  logic [1:0]     cur_op,
  input  logic           up_keyon,
  input  logic [CHW-1:0] keyon_ch,
  input  logic [NOP-1:0] keyon_op,
  input  logic           csm,
  input  logic           overflow_A,
  output logic           keyon_II,
  output logic           kon_pls,
  output logic           koff_pls,
  output logic           busy
);

  localparam int RING = ring_len(NCH, NOP);
  localparam int CNTW = $clog2(RING + 1);

  // request / CSM control state
  logic                 busy_r;
  logic [CHW-1:0]       pend_ch;
  logic [NOP_MAX-1:0]   pend_mask;
  logic [CNTW-1:0]      pass_cnt;
  logic                 csm_pend;
  logic                 csm_act;

  // slot datapath
  logic       key_out;
  logic       last_out;
  logic       key_p0;
  logic       level_p0;
  logic       kon_p0;
  logic       koff_p0;
  logic [1:0] bit_idx;
  logic       last_op;
  logic       pend_valid;
  logic       ch_hit;
  logic       csm_slot;
  logic       arm;
  logic       force_on;

  // ---- stage p0: current slot evaluation
  always_comb begin
    bit_idx    = op_bit(cur_op, NOP);
    last_op    = (cur_op == 2'(NOP - 1));
    pend_valid = (int'(pend_ch) < NCH);
    ch_hit     = busy_r && (cur_ch == pend_ch);
    key_p0     = ch_hit ? pend_mask[bit_idx] : key_out;
    csm_slot   = (int'(cur_ch) == CSM_CH);
    arm        = csm && csm_pend && csm_slot && (cur_op == 2'd0);
    // CSM forces the output level only; the stored key is left untouched.
    force_on   = csm_slot && (csm_act || arm);
    level_p0   = key_p0 | force_on;
    kon_p0     = level_p0 & ~last_out;
    koff_p0    = ~level_p0 & last_out;
  end

  jt12_sh_rst #(.WIDTH(1), .STAGES(RING), .RSTVAL(1'b0)) u_key_ring (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .din    (key_p0),
    .drop   (key_out)
  );

  jt12_sh_rst #(.WIDTH(1), .STAGES(RING), .RSTVAL(1'b0)) u_last_ring (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .din    (level_p0),
    .drop   (last_out)
  );

  // ---- stage p1: registered outputs and control update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keyon_II  <= 1'b0;
      kon_pls   <= 1'b0;
      koff_pls  <= 1'b0;
      busy_r    <= 1'b0;
      pend_ch   <= '0;
      pend_mask <= '0;
      pass_cnt  <= '0;
      csm_pend  <= 1'b0;
      csm_act   <= 1'b0;
    end else if (clk_en) begin
      keyon_II <= level_p0;
      kon_pls  <= kon_p0;
      koff_pls <= koff_p0;

      // A new write always wins, even on the slot that would end the old one.
      if (up_keyon) begin
        busy_r    <= 1'b1;
        pend_ch   <= keyon_ch;
        pend_mask <= NOP_MAX'(keyon_op);
        pass_cnt  <= '0;
      end else if (busy_r) begin
        if (pend_valid) begin
          if (ch_hit && last_op) busy_r <= 1'b0;
        end else if (pass_cnt == CNTW'(RING - 1)) begin
          // out-of-range channel never matches: release after a full pass
          busy_r <= 1'b0;
        end else begin
          pass_cnt <= pass_cnt + 1'b1;
        end
      end

      csm_pend <= csm && ((csm_pend && !arm) || overflow_A);
      if (arm)                 csm_act <= 1'b1;
      if (csm_slot && last_op) csm_act <= 1'b0;
    end
  end

  assign busy = busy_r;

endmodule

// File: tb/tb_jt12_kon_multi.sv
module tb_jt12_kon_multi;

  localparam int NCH    = 6;
  localparam int NOP    = 4;
  localparam int CSM_CH = 2;
  localparam int CHW    = 3;
  localparam int RING   = NCH * NOP;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           clk_en = 1'b0;
  logic [CHW-1:0] cur_ch = '0;
  logic [1:0]     cur_op = '0;
  logic           up_keyon = 1'b0;
  logic [CHW-1:0] keyon_ch = '0;
  logic [NOP-1:0] keyon_op = '0;
  logic           csm = 1'b0;
  logic           overflow_A = 1'b0;
  logic           keyon_II, kon_pls, koff_pls, busy;

  jt12_kon_multi #(.NCH(NCH), .NOP(NOP), .CSM_CH(CSM_CH), .CHW(CHW)) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .cur_ch     (cur_ch),
    .cur_op     (cur_op),
    .up_keyon   (up_keyon),
    .keyon_ch   (keyon_ch),
    .keyon_op   (keyon_op),
    .csm        (csm),
    .overflow_A (overflow_A),
    .keyon_II   (keyon_II),
    .kon_pls    (kon_pls),
    .koff_pls   (koff_pls),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  // ---- reference model: key state per (channel, mask bit)
  int  opmap [4] = '{0, 2, 1, 3};   // sequencer op -> mask bit (S1,S3,S2,S4)
  bit  st  [NCH][4];
  bit  lst [NCH][4];
  bit  m_busy, m_cpend, m_cact;
  int  m_ch, m_cnt;
  bit  [3:0] m_mask;
  bit  e_lvl, e_kon, e_koff;
  int  s = 0;                        // sequencer slot position

  // per-test observation counters
  int  c_lvl, c_kon, c_koff, c_fall;
  bit  prev_busy;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++)
      for (int b = 0; b < 4; b++) begin st[c][b] = 0; lst[c][b] = 0; end
    m_busy = 0; m_cpend = 0; m_cact = 0; m_ch = 0; m_cnt = 0; m_mask = '0;
    e_lvl = 0; e_kon = 0; e_koff = 0; prev_busy = 0;
  endtask

  task automatic clr_counts();
    c_lvl = 0; c_kon = 0; c_koff = 0; c_fall = 0;
  endtask

  task automatic model_step(input bit up, input int kch, input bit [3:0] kop, input bit ovf);
    int  ch, op, b;
    bit  cslot, arm, lvl;
    ch = s % NCH;
    op = s / NCH;
    b  = opmap[op];
    if (m_busy && ch == m_ch) st[ch][b] = m_mask[b];
    cslot = (ch == CSM_CH);
    arm   = csm && m_cpend && cslot && op == 0;
    lvl   = st[ch][b] | (cslot && (m_cact || arm));
    e_kon  = lvl && !lst[ch][b];
    e_koff = !lvl && lst[ch][b];
    e_lvl  = lvl;
    lst[ch][b] = lvl;
    if (cslot && op == NOP - 1) m_cact = 0;
    if (arm) m_cact = 1;
    m_cpend = csm && ((m_cpend && !arm) || ovf);
    if (up) begin
      m_busy = 1; m_ch = kch; m_mask = kop; m_cnt = 0;
    end else if (m_busy) begin
      if (m_ch < NCH) begin
        if (ch == m_ch && op == NOP - 1) m_busy = 0;
      end else begin
        m_cnt++;
        if (m_cnt == RING) m_busy = 0;
      end
    end
  endtask

  task automatic step(input bit en, input bit up, input int kch, input bit [3:0] kop, input bit ovf);
    @(negedge clk);
    clk_en     = en;
    cur_ch     = CHW'(s % NCH);
    cur_op     = 2'(s / NCH);
    up_keyon   = up;
    keyon_ch   = CHW'(kch);
    keyon_op   = kop;
    overflow_A = ovf;
    if (en) model_step(up, kch, kop, ovf);
    @(posedge clk);
    #1;
    chk("keyon_II", int'(keyon_II), int'(e_lvl));
    chk("kon_pls",  int'(kon_pls),  int'(e_kon));
    chk("koff_pls", int'(koff_pls), int'(e_koff));
    chk("busy",     int'(busy),     int'(m_busy));
    chk("pulse_excl", int'(kon_pls & koff_pls), 0);
    if (en) begin
      c_lvl  += int'(keyon_II);
      c_kon  += int'(kon_pls);
      c_koff += int'(koff_pls);
      if (prev_busy && !busy) c_fall++;
      prev_busy = busy;
      s = (s + 1) % RING;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 4'h0, 0);
  endtask

  task automatic goto_slot(input int t);
    for (int i = 0; i < RING && s != t; i++) step(1, 0, 0, 4'h0, 0);
  endtask

  initial begin
    model_reset();
    clr_counts();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_keyon_II", int'(keyon_II), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: idle
    run(48);
    chk("t1_lvl", c_lvl, 0);
    chk("t1_pulses", c_kon + c_koff, 0);

    // 2: key on all ops of ch1
    goto_slot(0);
    clr_counts();
    step(1, 1, 1, 4'hF, 0);
    run(RING - 1);
    chk("t2_lvl", c_lvl, 4);
    chk("t2_kon", c_kon, 4);
    chk("t2_busy_end", int'(busy), 0);
    clr_counts();
    run(RING);
    chk("t2_hold_lvl", c_lvl, 4);
    chk("t2_hold_kon", c_kon, 0);

    // 3: key off ch1
    clr_counts();
    step(1, 1, 1, 4'h0, 0);
    run(RING - 1);
    chk("t3_koff", c_koff, 4);
    chk("t3_kon", c_kon, 0);
    clr_counts();
    run(RING);
    chk("t3_quiet", c_kon + c_koff, 0);

    // 4: CSM pass on CSM_CH
    csm = 1'b1;
    clr_counts();
    step(1, 0, 0, 4'h0, 1);
    run(RING - 1);
    chk("t4_lvl", c_lvl, 4);
    chk("t4_kon", c_kon, 4);
    clr_counts();
    run(RING);
    chk("t4_koff", c_koff, 4);
    chk("t4_stored", c_lvl, 0);
    csm = 1'b0;

    // 5: latest write wins
    goto_slot(RING - 2);
    clr_counts();
    step(1, 1, 0, 4'b0001, 0);
    step(1, 1, 0, 4'b0100, 0);
    run(RING - 2);
    clr_counts();
    run(RING);
    chk("t5_lvl", c_lvl, 1);
    chk("t5_busy", int'(busy), 0);

    // busy fall count covered separately from a fresh start
    goto_slot(RING - 2);
    clr_counts();
    step(1, 1, 0, 4'b0001, 0);
    step(1, 1, 0, 4'b0000, 0);
    run(2 * RING);
    chk("t5_falls", c_fall, 1);

    // 6: async reset mid-pass
    goto_slot(0);
    step(1, 1, 3, 4'hF, 0);
    run(5);
    chk("t6_busy_pre", int'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_keyon", int'(keyon_II), 0);
    chk("t6_rst_kon", int'(kon_pls), 0);
    chk("t6_rst_koff", int'(koff_pls), 0);
    chk("t6_rst_busy", int'(busy), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    clr_counts();
    run(RING);
    chk("t6_ring_clear", c_lvl, 0);

    // randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      bit en, up, ovf;
      en  = ($urandom_range(0, 9) < 8);
      up  = ($urandom_range(0, 29) == 0);
      ovf = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 99) == 0) csm = ~csm;
      step(en, up, int'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), ovf);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
